// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath blocks: operation
// encodings, multiply/divide FSM states and the default operand width.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FINISH
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign correction applied to the raw magnitude result when
// mult_div_unit is built with MULTDIV_SIGNED_EN.
module md_sign_fix
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] raw,
  input  md_op_e             op,
  input  logic               neg_res,
  input  logic               neg_rem,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // NOTE: every path below assigns hi and lo, so no latch is inferred.
  always_comb begin
    prod = neg_res ? -raw : raw;
    quo  = neg_res ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    rem  = neg_rem ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    if (op == MD_DIV) begin
      hi = rem;
      lo = quo;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential shift-add multiplier / restoring divider feeding HI/LO.
// Define MULTDIV_SIGNED_EN for two's-complement (MIPS mult/div) operands.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  md_op_e             op_q;
  logic [WIDTH:0]     opnd_q;
  logic [2*WIDTH-1:0] acc;

  md_op_e             req_op;
  logic               div_by_zero;
  logic [WIDTH:0]     a_mag;
  logic [WIDTH:0]     b_mag;
  logic [WIDTH:0]     lo_src;
  logic [WIDTH:0]     opnd_src;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] acc_next;

  assign req_op      = md_op_e'(md_op);
  assign div_by_zero = (req_op == MD_DIV) && (b == '0);

  // Magnitudes carry one extra bit so that |-2^(WIDTH-1)| is representable.
`ifdef MULTDIV_SIGNED_EN
  always_comb begin
    a_mag = a[WIDTH-1] ? -{a[WIDTH-1], a} : {a[WIDTH-1], a};
    b_mag = b[WIDTH-1] ? -{b[WIDTH-1], b} : {b[WIDTH-1], b};
  end
`else
  assign a_mag = {1'b0, a};
  assign b_mag = {1'b0, b};
`endif

  // acc low half starts as the multiplier (mult) or the dividend (div).
  assign lo_src   = (req_op == MD_DIV) ? a_mag : b_mag;
  assign opnd_src = (req_op == MD_DIV) ? b_mag : a_mag;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? opnd_q : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = {1'b0, div_shift} - {1'b0, opnd_q};
    if (op_q == MD_DIV) begin
      if (!div_trial[WIDTH+1]) acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                     acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Magnitude MSB of the low-half operand and the trial bit above the
  // remainder are always zero where they are dropped.
  logic unused_bits;
  assign unused_bits = ^{lo_src[WIDTH], div_trial[WIDTH]};

`ifdef MULTDIV_SIGNED_EN
  logic neg_res_q;
  logic neg_rem_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state == MD_IDLE && start && !div_by_zero) begin
      neg_res_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem_q <= a[WIDTH-1];
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw     (acc),
    .op      (op_q),
    .neg_res (neg_res_q),
    .neg_rem (neg_rem_q),
    .hi      (fin_hi),
    .lo      (fin_lo)
  );
`else
  assign fin_hi = acc[2*WIDTH-1:WIDTH];
  assign fin_lo = acc[WIDTH-1:0];
`endif

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values, matching flop behaviour in simulation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op_q   <= MD_MULT;
      opnd_q <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start && div_by_zero) begin
            div0 <= 1'b1;
          end else if (start) begin
            op_q   <= req_op;
            opnd_q <= opnd_src;
            acc    <= {{WIDTH{1'b0}}, lo_src[WIDTH-1:0]};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= MD_FINISH;
        end
        MD_FINISH: begin
          hi    <= fin_hi;
          lo    <= fin_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations against an arithmetic reference (signedness follows MULTDIV_SIGNED_EN).
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         md_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div0;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values, truncated to W.
  function automatic void model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
`ifdef MULTDIV_SIGNED_EN
    longint sx, sy, p;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    if (op == OP_DIV) begin
      eh = 32'(sx % sy);
      el = 32'(sx / sy);
    end else begin
      p  = sx * sy;
      eh = 32'(p >>> 32);
      el = 32'(p);
    end
`else
    longint unsigned ux, uy, p;
    ux = longint'(x);
    uy = longint'(y);
    if (op == OP_DIV) begin
      eh = 32'(ux % uy);
      el = 32'(ux / uy);
    end else begin
      p  = ux * uy;
      eh = 32'(p >> 32);
      el = 32'(p);
    end
`endif
  endfunction

  task automatic run_op(input logic op, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    logic [W-1:0] eh, el;
    int ndone;
    @(negedge clock);
    start = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    @(posedge clock);
    #1;
    if (op == OP_DIV && y == '0) begin
      start = 1'b0;
      check("div0_pulse", {61'd0, div0, busy, done}, 64'b100);
      @(posedge clock);
      #1;
      check("div0_clear", {61'd0, div0, busy, done}, 64'b000);
      check("div0_hi", hi, cur_hi);
      check("div0_lo", lo, cur_lo);
      return;
    end
    model(op, x, y, eh, el);
    if (!hold) start = 1'b0;
    check("start_busy", {61'd0, busy, done, div0}, 64'b100);
    ndone = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (hold) begin
        a     = $urandom;
        b     = $urandom;
        md_op = 1'($urandom);
      end
      @(posedge clock);
      #1;
      if (done) ndone++;
      if (c == W / 2) begin
        check("calc_flags", {62'd0, busy, done}, 64'b10);
        check("calc_hold_hi", hi, cur_hi);
        check("calc_hold_lo", lo, cur_lo);
      end
    end
    start = 1'b0;
    check("done_flags", {62'd0, busy, done}, 64'b01);
    check("result_hi", hi, eh);
    check("result_lo", lo, el);
    cur_hi = eh;
    cur_lo = el;
    @(posedge clock);
    #1;
    if (done) ndone++;
    check("done_drop", {62'd0, busy, done}, 64'b00);
    check("done_count", 64'(ndone), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int ndone;
    logic op;
    logic [W-1:0] x, y;

    reset = 1'b0;
    start = 1'b0;
    md_op = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_flags", {61'd0, busy, done, div0}, 64'b000);
    @(negedge clock);
    reset = 1'b1;

    run_op(OP_MULT, 32'd7, 32'd6, 1'b0);
    run_op(OP_MULT, -32'sd3, 32'd5, 1'b0);
    run_op(OP_DIV, 32'd100, 32'd7, 1'b0);
    run_op(OP_DIV, -32'sd7, 32'd2, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Leave hi=5, lo=9, then divide by zero.
    run_op(OP_DIV, 32'd95, 32'd10, 1'b0);
    run_op(OP_DIV, 32'd1234, 32'd0, 1'b0);

    // start held high throughout CALC.
    run_op(OP_MULT, 32'd1000, 32'd3000, 1'b1);

    // Reset after iteration 10.
    @(negedge clock);
    start = 1'b1;
    md_op = OP_MULT;
    a     = 32'd12345;
    b     = 32'd678;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_flags", {62'd0, busy, done}, 64'b00);
    @(negedge clock);
    reset = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    ndone = 0;
    for (int c = 0; c < W + 8; c++) begin
      @(posedge clock);
      #1;
      if (done || busy) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_op(OP_MULT, 32'd2, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom);
      x  = pick();
      y  = (op == OP_DIV && $urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 100)) : pick();
      run_op(op, x, y, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential multiply/divide unit that responds to the multicycle controller's `MDcontrol`/`HILOWrite` start request and reports `Div0` back to it. It computes the 64-bit product of `mult` or the quotient/remainder of `div`, and holds the result in the HI and LO registers for `mfhi`/`mflo`. It sits beside the ALU in the datapath, takes operands from the register file A/B latches, and feeds the HI/LO inputs of the `WriteData` mux.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `start`  in  1  operation request, sampled only in IDLE (controller drives this from `HILOWrite`).
- `md_op`  in  1  0 = mult, 1 = div (controller's `MDcontrol`).
- `a`  in  WIDTH  rs operand: multiplicand or dividend.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `hi`  out  WIDTH  HI register: product[63:32] or remainder.
- `lo`  out  WIDTH  LO register: product[31:0] or quotient.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.
- `div0`  out  1  one-cycle pulse when a div is requested with `b == 0`.

## Operation
- Reset values: `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`, `div0 = 0`, state IDLE, counter 0.
- States: IDLE, CALC, FINISH.
- IDLE, `start = 1`, `md_op = 1`, `b == 0`:
  - Register `div0 = 1` for one cycle and stay in IDLE.
  - HI/LO are unchanged and `busy` stays 0.
- IDLE, `start = 1`, otherwise:
  - Latch the magnitudes of `a` and `b`, the result signs, and `md_op`.
  - Clear the counter, set `busy = 1`, go to CALC.
- CALC runs one iteration per cycle, exactly WIDTH iterations, then goes to FINISH.
  - mult: shift-add on a 2·WIDTH accumulator. If multiplier bit 0 is set, add the multiplicand into the upper half, then shift the accumulator right 1.
  - div: restoring division. Shift the {remainder, quotient} pair left 1 and trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set quotient bit 0.
- FINISH:
  - Apply sign correction and write HI/LO.
  - Set `done = 1`, clear `busy`, return to IDLE.
- Sign rules (with signed support enabled):
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - −2^31 / −1 gives `lo = 0x80000000`, `hi = 0`, with no flag.
- Width rules:
  - Magnitudes are computed on WIDTH+1 bits internally so |−2^31| is representable.
  - All results are truncated to WIDTH.
- `start` while `busy`: ignored; no queueing.
- Reset mid-operation: the operation is aborted, HI/LO are cleared, and no `done` is issued.

## Timing
- `start` sampled at edge 0: `busy` is 1 after edge 0.
- Edges 1..WIDTH: iterations; the transition to FINISH happens at edge WIDTH.
- Edge WIDTH+1: HI/LO updated, `done = 1`, `busy = 0`.
- Edge WIDTH+2: `done = 0`. A new `start` can already be sampled at this edge.
- Total latency from `start` to `done` is WIDTH+1 cycles (33 for WIDTH = 32).
- Division by zero: `div0` is high for the single cycle after edge 0.
- HI/LO hold their values between operations. Reading them during CALC returns the previous result.

## Configuration
- `MULTDIV_SIGNED_EN` defined:
  - Operands are two's-complement, with the sign handling described above (MIPS `mult`/`div`).
- `MULTDIV_SIGNED_EN` undefined:
  - Operands are unsigned, the sign-latch and correction logic is removed, and FINISH writes the raw results.
  - Cycle timing is identical in both builds.

## Structure
- Shared package `mips_pkg`:
  - `md_op` encodings (`MD_MULT = 0`, `MD_DIV = 1`).
  - The state enum.
  - `WIDTH` default.
- Sub-module `md_sign_fix`: combinational negate and select used in FINISH. It is instantiated only under `MULTDIV_SIGNED_EN`.
- Iteration datapath and FSM live in `mult_div_unit`.

## Test plan
- mult `a = 7`, `b = 6` → after 33 cycles `done` pulses; `hi = 0`, `lo = 42`.
- mult `a = −3`, `b = 5` (signed build) → `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFF1`.
- div `a = 100`, `b = 7` → `lo = 14`, `hi = 2`. Then div `a = −7`, `b = 2` → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`.
- div `b = 0` with prior `hi = 5`, `lo = 9` → `div0` high for exactly one cycle, `busy` never high, `hi`/`lo` still 5/9.
- `start` re-asserted every cycle during CALC → exactly one `done`, with the first operation's result.
- Reset asserted at iteration 10 → `hi = lo = 0`, `busy = 0`, no `done` pulse. A new mult 2·3 afterwards gives `lo = 6`.
